// File: rtl/nonrestoring_divider.sv
// rtl/nonrestoring_divider.sv - 32-bit signed non-restoring divider (remainder port via DIV_REMAINDER_OUT_EN)
module nonrestoring_divider (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        start,
  output logic [31:0] result,
  output logic        ready,
  output logic        exception
`ifdef DIV_REMAINDER_OUT_EN
  ,
  output logic [31:0] remainder
`endif
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DIVIDE = 2'd1;
  localparam logic [1:0] FIX    = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  logic [1:0]  state;
  logic [5:0]  count;
  logic [64:0] sr;
  logic [32:0] b_abs;
  logic        a_neg;
  logic        b_neg;
  logic        div0;

  logic [31:0] a_abs_in;
  logic [32:0] b_abs_in;
  logic [64:0] sr_shift;
  logic [32:0] rem_step;
  logic [64:0] sr_step;
  logic [31:0] quo_fix;
  logic [32:0] rem_fix;

  // Magnitudes are unsigned, so |0x80000000| stays 0x80000000 without overflow
  assign a_abs_in = A[31] ? -A : A;
  assign b_abs_in = {1'b0, (B[31] ? -B : B)};

  // One non-restoring step: shift, then add or subtract |B| on the old remainder sign
  assign sr_shift = {sr[63:0], 1'b0};
  assign rem_step = sr[64] ? (sr_shift[64:32] + b_abs) : (sr_shift[64:32] - b_abs);
  assign sr_step  = {rem_step, sr_shift[31:1], ~rem_step[32]};

  assign quo_fix = (a_neg ^ b_neg) ? -sr[31:0] : sr[31:0];

`ifdef DIV_REMAINDER_OUT_EN
  logic [32:0] rem_pos;
  assign rem_pos = sr[64] ? (sr[64:32] + b_abs) : sr[64:32];
  assign rem_fix = a_neg ? -rem_pos : rem_pos;
`else
  assign rem_fix = sr[64:32];
`endif

  // DONE publishes the finished word; ready is the registered pulse that follows it
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      count     <= 6'd0;
      sr        <= 65'd0;
      b_abs     <= 33'd0;
      a_neg     <= 1'b0;
      b_neg     <= 1'b0;
      div0      <= 1'b0;
      result    <= 32'd0;
      ready     <= 1'b0;
      exception <= 1'b0;
`ifdef DIV_REMAINDER_OUT_EN
      remainder <= 32'd0;
`endif
    end else begin
      ready <= 1'b0;
      if (start) begin
        // A start in any state begins a fresh operation and abandons the current one
        a_neg <= A[31];
        b_neg <= B[31];
        b_abs <= b_abs_in;
        count <= 6'd0;
        if (B == 32'd0) begin
          state <= DONE;
          div0  <= 1'b1;
`ifdef DIV_REMAINDER_OUT_EN
          sr    <= {A[31], A, 32'd0};
`else
          sr    <= 65'd0;
`endif
        end else begin
          state <= DIVIDE;
          div0  <= 1'b0;
          sr    <= {33'd0, a_abs_in};
        end
      end else begin
        case (state)
          DIVIDE: begin
            sr    <= sr_step;
            count <= count + 6'd1;
            if (count == 6'd31) begin
              state <= FIX;
            end
          end
          FIX: begin
            sr    <= {rem_fix, quo_fix};
            state <= DONE;
          end
          DONE: begin
            ready     <= 1'b1;
            result    <= sr[31:0];
            exception <= div0;
`ifdef DIV_REMAINDER_OUT_EN
            remainder <= sr[63:32];
`endif
            state     <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_nonrestoring_divider.sv
// tb/tb_nonrestoring_divider.sv - randomized self-checking bench for nonrestoring_divider
module tb_nonrestoring_divider;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic [31:0] result;
  logic        ready;
  logic        exception;
`ifdef DIV_REMAINDER_OUT_EN
  logic [31:0] remainder;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  nonrestoring_divider dut (
    .clock(clock),
    .reset(reset),
    .A(A),
    .B(B),
    .start(start),
    .result(result),
    .ready(ready),
    .exception(exception)
`ifdef DIV_REMAINDER_OUT_EN
    ,
    .remainder(remainder)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: plain 64-bit signed arithmetic, truncation toward zero
  task automatic model(input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] q, output logic [31:0] r, output logic e);
    longint sa, sb, lq, lr;
    sa = $signed(a);
    sb = $signed(b);
    if (sb == 0) begin
      q = 32'd0;
      r = a;
      e = 1'b1;
    end else begin
      lq = sa / sb;
      lr = sa - lq * sb;
      q  = lq[31:0];
      r  = lr[31:0];
      e  = 1'b0;
    end
  endtask

  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    A = a;
    B = b;
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    A = $urandom;
    B = $urandom;
  endtask

  task automatic wait_ready(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input int exp_lat);
    int edges;
    logic [31:0] q, r;
    logic e;
    edges = 0;
    model(a, b, q, r, e);
    while (edges < 60 && ready !== 1'b1) begin
      @(posedge clock);
      #1;
      edges++;
    end
    check({tag, ".lat"}, 64'(edges), 64'(exp_lat));
    check({tag, ".res"}, {32'd0, result}, {32'd0, q});
    check({tag, ".exc"}, {63'd0, exception}, {63'd0, e});
`ifdef DIV_REMAINDER_OUT_EN
    check({tag, ".rem"}, {32'd0, remainder}, {32'd0, r});
`endif
    @(posedge clock);
    #1;
    check({tag, ".pulse"}, {63'd0, ready}, 64'd0);
    check({tag, ".hold"}, {32'd0, result}, {32'd0, q});
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b);
    start_op(a, b);
    wait_ready(tag, a, b, (b == 32'd0) ? 1 : 34);
  endtask

  logic [31:0] dir_a [10] = '{32'd100, -32'd100, 32'd5, 32'h80000000, 32'h80000000,
                              32'h80000000, 32'd7, 32'h7fffffff, 32'd0, -32'd7};
  logic [31:0] dir_b [10] = '{32'd7, 32'd7, 32'd0, 32'hffffffff, 32'd2,
                              32'h80000000, 32'h80000000, 32'd1, 32'd5, -32'd2};
  int abort_at [3] = '{20, 33, 34};

  initial begin
    int seen;
    logic [31:0] ra, rb;

    #12;
    check("rst.res", {32'd0, result}, 64'd0);
    check("rst.rdy", {63'd0, ready}, 64'd0);
    check("rst.exc", {63'd0, exception}, 64'd0);
    @(negedge clock);
    reset = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run_op($sformatf("dir%0d", i), dir_a[i], dir_b[i]);
    end

    // Asynchronous reset in the middle of DIVIDE
    run_op("pre_rst", 32'd100, 32'd7);
    start_op(32'd50, 32'd5);
    repeat (10) @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    check("async.res", {32'd0, result}, 64'd0);
    check("async.rdy", {63'd0, ready}, 64'd0);
    check("async.exc", {63'd0, exception}, 64'd0);
`ifdef DIV_REMAINDER_OUT_EN
    check("async.rem", {32'd0, remainder}, 64'd0);
`endif
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge clock);
      #1;
      if (ready) seen++;
    end
    check("async.noready", 64'(seen), 64'd0);
    run_op("post_rst", 32'd9, 32'd3);

    // Restart while DIVIDE, FIX and DONE are in progress
    for (int k = 0; k < 3; k++) begin
      start_op(32'd50, 32'd5);
      seen = 0;
      repeat (abort_at[k] - 1) begin
        @(posedge clock);
        #1;
        if (ready) seen++;
      end
      start_op(32'd81, -32'd9);
      check($sformatf("abort%0d.noready", abort_at[k]), 64'(seen), 64'd0);
      wait_ready($sformatf("abort%0d", abort_at[k]), 32'd81, -32'd9, 34);
    end

    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 3))
        0: rb = 32'd0;
        1: rb = $urandom_range(0, 40) - 32'd20;
        default: rb = $urandom;
      endcase
      ra = ($urandom_range(0, 1) == 0) ? ($urandom_range(0, 2000) - 32'd1000) : $urandom;
      run_op($sformatf("rnd%0d", n), ra, rb);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
